// File: rtl/pattern_sched_if.sv
// Request/grant and detection-result bundle for pattern_sched.
// The requester side drives req/bit_in/len; the scheduler drives everything else.
interface pattern_sched_if;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] len;
  logic [3:0] gnt;
  logic       busy;
  logic       det_pulse;
  logic       done;
  logic [1:0] done_id;
  logic [3:0] match_cnt;

  modport master (
    output req, bit_in, len,
    input  gnt, busy, det_pulse, done, done_id, match_cnt
  );

  modport slave (
    input  req, bit_in, len,
    output gnt, busy, det_pulse, done, done_id, match_cnt
  );
endinterface

// File: rtl/pattern_sched.sv
// Round-robin scheduler that grants one of four requesters a burst of serial
// samples and counts non-overlapping equal-bit pairs in that burst.
module pattern_sched (
  input  logic           clk,
  input  logic           rst,
  pattern_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2} det_t;

  state_t     state_reg;
  det_t       det_reg;
  logic [1:0] ptr_reg;
  logic [1:0] owner_reg;
  logic [4:0] len_reg;
  logic [4:0] cnt_reg;
  logic [3:0] gnt_reg;
  logic [3:0] match_reg;
  logic       busy_reg;
  logic       pulse_reg;
  logic       done_reg;
  logic [1:0] done_id_reg;

  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] win_id;
  logic [4:0] len_eff;
  logic [4:0] cnt_next;
  logic       sample;
  det_t       det_next;
  logic       hit;

  // Rotate requests so position 0 is the requester the pointer names.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFF = 2'(gi);
      assign rot_req[gi] = bus.req[ptr_reg + OFF];
    end
  endgenerate

  always_comb begin
    win_off = 2'd3;
    if (rot_req[0])      win_off = 2'd0;
    else if (rot_req[1]) win_off = 2'd1;
    else if (rot_req[2]) win_off = 2'd2;
  end

  assign win_id   = ptr_reg + win_off;
  assign len_eff  = (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
  assign cnt_next = cnt_reg + 5'd1;
  assign sample   = bus.bit_in[owner_reg];

  // A match consumes both bits of the pair, so the detector restarts from S0.
  always_comb begin
    det_next = S0;
    hit      = 1'b0;
    case (det_reg)
      S0: det_next = sample ? S1 : S2;
      S1: begin
        if (sample) begin
          det_next = S0;
          hit      = 1'b1;
        end else begin
          det_next = S2;
        end
      end
      S2: begin
        if (!sample) begin
          det_next = S0;
          hit      = 1'b1;
        end else begin
          det_next = S1;
        end
      end
      default: det_next = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      det_reg     <= S0;
      ptr_reg     <= 2'd0;
      owner_reg   <= 2'd0;
      len_reg     <= 5'd0;
      cnt_reg     <= 5'd0;
      gnt_reg     <= 4'd0;
      match_reg   <= 4'd0;
      busy_reg    <= 1'b0;
      pulse_reg   <= 1'b0;
      done_reg    <= 1'b0;
      done_id_reg <= 2'd0;
    end else begin
      pulse_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_reg <= RUN;
            owner_reg <= win_id;
            ptr_reg   <= win_id + 2'd1;
            gnt_reg   <= 4'b0001 << win_id;
            busy_reg  <= 1'b1;
            len_reg   <= len_eff;
            cnt_reg   <= 5'd0;
            match_reg <= 4'd0;
            det_reg   <= S0;
          end
        end
        RUN: begin
          det_reg <= det_next;
          cnt_reg <= cnt_next;
          if (hit) begin
            pulse_reg <= 1'b1;
            match_reg <= match_reg + 4'd1;
          end
          if (cnt_next == len_reg) begin
            state_reg   <= DONE;
            gnt_reg     <= 4'd0;
            done_reg    <= 1'b1;
            done_id_reg <= owner_reg;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.busy      = busy_reg;
  assign bus.det_pulse = pulse_reg;
  assign bus.done      = done_reg;
  assign bus.done_id   = done_id_reg;
  assign bus.match_cnt = match_reg;
endmodule

// File: tb/tb_pattern_sched.sv
// Directed bench for pattern_sched: a timestamp-based burst model checked every
// cycle, plus literal per-scenario expectations.
module tb_pattern_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_sched_if bus ();
  pattern_sched dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst model: a grant at edge g with length L means samples at edges
  // g+1..g+L, done in the cycle after edge g+L, back in IDLE after g+L+1.
  bit         started = 1'b0;
  int         e = 0;
  bit         m_active = 1'b0;
  int         m_g = 0, m_L = 0, m_own = 0, m_ptr = 0, m_cnt = 0;
  bit         m_prev_v = 1'b0, m_prev = 1'b0;
  logic [3:0] exp_gnt = 4'd0;
  logic       exp_busy = 1'b0, exp_det = 1'b0, exp_done = 1'b0, exp_rst = 1'b0;
  logic [1:0] exp_id = 2'd0;
  logic [3:0] exp_mc = 4'd0;

  always @(posedge clk) begin
    logic b;
    int   pick;
    started = 1'b1;
    e++;
    exp_det = 1'b0;
    exp_rst = 1'b0;
    if (!rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_cnt    = 0;
      m_own    = 0;
      m_prev_v = 1'b0;
      exp_rst  = 1'b1;
    end else if (m_active) begin
      if (e <= m_g + m_L) begin
        b = bus.bit_in[m_own];
        if (m_prev_v && m_prev == b) begin
          m_cnt++;
          exp_det  = 1'b1;
          m_prev_v = 1'b0;
        end else begin
          m_prev   = b;
          m_prev_v = 1'b1;
        end
      end else begin
        m_active = 1'b0;
      end
    end else if (bus.req != 4'd0) begin
      pick = -1;
      for (int i = 0; i < 4; i++)
        if (pick < 0 && bus.req[(m_ptr + i) % 4]) pick = (m_ptr + i) % 4;
      m_own    = pick;
      m_g      = e;
      m_L      = (bus.len == 4'd0) ? 16 : int'(bus.len);
      m_ptr    = (pick + 1) % 4;
      m_cnt    = 0;
      m_prev_v = 1'b0;
      m_active = 1'b1;
    end
    exp_gnt  = (m_active && e < m_g + m_L) ? 4'(1 << m_own) : 4'd0;
    exp_busy = m_active;
    exp_done = m_active && (e == m_g + m_L);
    exp_id   = exp_rst ? 2'd0 : 2'(m_own);
    exp_mc   = 4'(m_cnt);
  end

  // Observation log used by the literal per-scenario checks.
  logic [3:0] prev_gnt = 4'd0;
  logic [3:0] glog[8];
  int gn = 0, n_done = 0, n_det = 0, gcycles = 0, last_id = -1, last_mc = -1;

  always @(negedge clk) begin
    logic oh;
    if (started) begin
      chk("gnt", bus.gnt, exp_gnt);
      chk("busy", {3'b0, bus.busy}, {3'b0, exp_busy});
      chk("det_pulse", {3'b0, bus.det_pulse}, {3'b0, exp_det});
      chk("done", {3'b0, bus.done}, {3'b0, exp_done});
      if (exp_done || exp_rst) begin
        chk("done_id", {2'b0, bus.done_id}, {2'b0, exp_id});
        chk("match_cnt", bus.match_cnt, exp_mc);
      end
      oh = $onehot0(bus.gnt);
      chk("gnt_onehot0", {3'b0, oh}, 4'd1);
      if (bus.gnt != 4'd0 && prev_gnt == 4'd0) begin
        if (gn < 8) glog[gn] = bus.gnt;
        gn++;
      end
      if (bus.gnt != 4'd0) gcycles++;
      if (bus.det_pulse) n_det++;
      if (bus.done) begin
        n_done++;
        last_id = int'(bus.done_id);
        last_mc = int'(bus.match_cnt);
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic clear_logs();
    gn = 0; n_done = 0; n_det = 0; gcycles = 0; last_id = -1; last_mc = -1;
  endtask

  // Present a request at the current negedge, feed n samples on the given lane
  // (other lanes carry the inverse), then wait for done and return to IDLE.
  task automatic burst(input logic [3:0] r, input logic [3:0] l, input int lane,
                       input logic [15:0] bits, input int n, input bit hold,
                       output int done_at);
    int c;
    bus.req = r;
    bus.len = l;
    @(negedge clk);
    c = 1;
    if (!hold) bus.req = 4'd0;
    for (int i = 0; i < n; i++) begin
      bus.bit_in = bits[i] ? (4'b0001 << lane) : ~(4'b0001 << lane);
      @(negedge clk);
      c++;
    end
    bus.bit_in = 4'd0;
    while (!bus.done && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!bus.done) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", c);
    end
    done_at = c;
    bus.req = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    int d;
    rst = 1'b0;
    bus.req = 4'd0;
    bus.bit_in = 4'd0;
    bus.len = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Requester 0, bits 1,1,1,1: two pairs.
    clear_logs();
    burst(4'b0001, 4'd4, 0, 16'b1111, 4, 1'b1, d);
    chk_i("s1_first_gnt", int'(glog[0]), 1);
    chk_i("s1_gnt_cycles", gcycles, 4);
    chk_i("s1_det_count", n_det, 2);
    chk_i("s1_done_id", last_id, 0);
    chk_i("s1_match_cnt", last_mc, 2);
    chk_i("s1_done_at", d, 5);

    // Requester 2, bits 1,0,0,1: one pair in the middle.
    clear_logs();
    burst(4'b0100, 4'd4, 2, 16'b1001, 4, 1'b0, d);
    chk_i("s2_first_gnt", int'(glog[0]), 4);
    chk_i("s2_det_count", n_det, 1);
    chk_i("s2_done_id", last_id, 2);
    chk_i("s2_match_cnt", last_mc, 1);

    // Reset in IDLE, then all requesters held with len=1: rotation from 0.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    bus.req = 4'hF;
    bus.len = 4'd1;
    bus.bit_in = 4'd0;
    for (int k = 0; k < 5; k++) begin
      int c;
      c = 0;
      @(negedge clk);
      while (!bus.done && c < 20) begin
        @(negedge clk);
        c++;
      end
      if (!bus.done) begin
        n_vec++;
        n_miss++;
        $display("FAIL rr_timeout: got no done for grant %0d, expected done", k);
      end
    end
    bus.req = 4'd0;
    @(negedge clk);
    chk_i("s3_grants", gn, 5);
    chk_i("s3_g0", int'(glog[0]), 1);
    chk_i("s3_g1", int'(glog[1]), 2);
    chk_i("s3_g2", int'(glog[2]), 4);
    chk_i("s3_g3", int'(glog[3]), 8);
    chk_i("s3_g4", int'(glog[4]), 1);
    chk_i("s3_dones", n_done, 5);
    chk_i("s3_match_cnt", last_mc, 0);

    // len=0 means 16 samples: alternating bits give no pairs, zeros give eight.
    clear_logs();
    burst(4'b0001, 4'd0, 0, 16'h5555, 16, 1'b0, d);
    chk_i("s4a_gnt_cycles", gcycles, 16);
    chk_i("s4a_match_cnt", last_mc, 0);
    chk_i("s4a_done_at", d, 17);
    clear_logs();
    burst(4'b0001, 4'd0, 0, 16'h0000, 16, 1'b0, d);
    chk_i("s4b_match_cnt", last_mc, 8);
    chk_i("s4b_det_count", n_det, 8);

    // Reset during the second sample abandons the burst without a done strobe.
    clear_logs();
    bus.req = 4'b0010;
    bus.len = 4'd4;
    @(negedge clk);
    bus.req = 4'd0;
    bus.bit_in = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s5_gnt", bus.gnt, 4'd0);
    chk("s5_busy", {3'b0, bus.busy}, 4'd0);
    chk("s5_done", {3'b0, bus.done}, 4'd0);
    chk("s5_match_cnt", bus.match_cnt, 4'd0);
    rst = 1'b1;
    clear_logs();
    burst(4'hF, 4'd1, 0, 16'h0000, 1, 1'b0, d);
    chk_i("s5_regrant", int'(glog[0]), 1);
    chk_i("s5_dones", n_done, 1);

    // Request dropped right after grant: len=3 burst still completes on time.
    clear_logs();
    burst(4'b1000, 4'd3, 3, 16'b011, 3, 1'b0, d);
    chk_i("s6_done_at", d, 4);
    chk_i("s6_done_id", last_id, 3);
    chk_i("s6_match_cnt", last_mc, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
